// File: rtl/ppwm_seq.sv
// Programmable PWM sequencer: free-running period counter, duty/scratch registers, small program memory.
// Build option PPWM_CMP_IMM_EN: CMP func 11 compares pwm against the zero-extended immediate.
module ppwm_seq #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned IMM_W = 6,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned IW    = IMM_W + 6
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic          prog_we_i,
    input  logic [AW-1:0] prog_addr_i,
    input  logic [IW-1:0] prog_wdata_i,
    output logic          pwm_o,
    output logic [AW-1:0] pc_o,
    output logic          halted_o,
    output logic          illegal_o
);
    localparam int unsigned SW = $clog2(WIDTH);

    localparam logic [2:0] CMD_CTRL   = 3'd0;
    localparam logic [2:0] CMD_SET    = 3'd1;
    localparam logic [2:0] CMD_ARITH  = 3'd2;
    localparam logic [2:0] CMD_SHIFT  = 3'd3;
    localparam logic [2:0] CMD_RSRV   = 3'd4;
    localparam logic [2:0] CMD_JUMP   = 3'd5;
    localparam logic [2:0] CMD_CMP    = 3'd6;
    localparam logic [2:0] CMD_BRANCH = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

    state_t           r_state;
    logic [AW-1:0]    r_pc;
    logic [WIDTH-1:0] r_gcnt;
    logic [WIDTH-1:0] r_pwm_val;
    logic [WIDTH-1:0] r_reg_val;
    logic             r_eq;
    logic             r_lt;
    logic             r_pwm;
    logic             r_halted;
    logic             r_illegal;
    logic [IW-1:0]    r_mem [DEPTH];

    logic [IW-1:0]    w_ins;
    logic [2:0]       w_cmd;
    logic             w_tgt;
    logic [1:0]       w_func;
    logic [IMM_W-1:0] w_imm;
    logic [WIDTH-1:0] w_zimm;
    logic [WIDTH-1:0] w_t_val;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH-1:0] w_arith;
    logic [SW:0]      w_amt_raw;
    logic [SW:0]      w_amt;
    logic [SW:0]      w_amt_inv;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_cmp_a;
    logic [WIDTH-1:0] w_cmp_b;
    logic             w_cond;
    logic [AW-1:0]    w_pc_inc;
    logic [AW-1:0]    w_pc_rel;

    // Program memory: writable only while idle, never reset.
    always_ff @(posedge clk_i) begin
        if (prog_we_i && (r_state == S_IDLE)) begin
            r_mem[prog_addr_i] <= prog_wdata_i;
        end
    end

    assign w_ins    = r_mem[r_pc];
    assign w_cmd    = w_ins[IW-1 -: 3];
    assign w_tgt    = w_ins[IW-4];
    assign w_func   = w_ins[IW-5 -: 2];
    assign w_imm    = w_ins[IMM_W-1:0];
    assign w_pc_inc = r_pc + AW'(1);
    assign w_pc_rel = r_pc + AW'($signed(w_imm));

    // Datapath: arithmetic with optional clamp, shifts/rotates, compare operands, branch condition.
    always_comb begin
        w_zimm  = WIDTH'(w_imm);
        w_t_val = w_tgt ? r_reg_val : r_pwm_val;
        w_sum   = w_func[0] ? ({2'b00, w_t_val} - (WIDTH+2)'($signed(w_imm)))
                            : ({2'b00, w_t_val} + (WIDTH+2)'($signed(w_imm)));
        if (!w_func[1])          w_arith = w_sum[WIDTH-1:0];
        else if (w_sum[WIDTH+1]) w_arith = '0;
        else if (w_sum[WIDTH])   w_arith = '1;
        else                     w_arith = w_sum[WIDTH-1:0];

        w_amt_raw = {1'b0, w_zimm[SW-1:0]};
        w_amt     = (w_amt_raw >= (SW+1)'(WIDTH)) ? (w_amt_raw - (SW+1)'(WIDTH)) : w_amt_raw;
        w_amt_inv = (SW+1)'(WIDTH) - w_amt;
        case (w_func)
            2'b00:   w_shift = w_t_val << w_amt;
            2'b01:   w_shift = w_t_val >> w_amt;
            2'b10:   w_shift = (w_t_val << w_amt) | (w_t_val >> w_amt_inv);
            default: w_shift = (w_t_val >> w_amt) | (w_t_val << w_amt_inv);
        endcase

        w_cmp_a = r_pwm_val;
        w_cmp_b = r_reg_val;
        case (w_func)
            2'b00:   begin w_cmp_a = r_gcnt;    w_cmp_b = r_pwm_val; end
            2'b01:   begin w_cmp_a = r_gcnt;    w_cmp_b = r_reg_val; end
            2'b10:   begin w_cmp_a = r_pwm_val; w_cmp_b = r_reg_val; end
`ifdef PPWM_CMP_IMM_EN
            default: begin w_cmp_a = r_pwm_val; w_cmp_b = w_zimm;    end
`else
            default: begin w_cmp_a = r_pwm_val; w_cmp_b = r_reg_val; end
`endif
        endcase

        case (w_func)
            2'b00:   w_cond = r_eq;
            2'b01:   w_cond = !r_eq;
            2'b10:   w_cond = r_lt;
            default: w_cond = !r_lt;
        endcase
    end

    // Sequencer state, counter, registers and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_gcnt    <= '0;
            r_pwm_val <= '0;
            r_reg_val <= '0;
            r_eq      <= 1'b0;
            r_lt      <= 1'b0;
            r_pwm     <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_pwm  <= en_i && (r_state != S_IDLE) && (r_gcnt < r_pwm_val);
            r_gcnt <= (en_i && (r_state != S_IDLE)) ? (r_gcnt + WIDTH'(1)) : '0;
            if (!en_i) begin
                r_state  <= S_IDLE;
                r_pc     <= '0;
                r_halted <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                    end
                    S_RUN: begin
                        r_pc <= w_pc_inc;
                        case (w_cmd)
                            CMD_CTRL: begin
                                case (w_func)
                                    2'b00: ;
                                    2'b01: begin r_state <= S_WAIT; r_pc <= r_pc; end
                                    2'b10: begin r_state <= S_HALT; r_pc <= r_pc; r_halted <= 1'b1; end
                                    default: r_pc <= '0;
                                endcase
                            end
                            CMD_SET: begin
                                if (w_tgt) r_reg_val <= w_zimm;
                                else       r_pwm_val <= w_zimm;
                            end
                            CMD_ARITH: begin
                                if (w_tgt) r_reg_val <= w_arith;
                                else       r_pwm_val <= w_arith;
                            end
                            CMD_SHIFT: begin
                                if (w_tgt) r_reg_val <= w_shift;
                                else       r_pwm_val <= w_shift;
                            end
                            CMD_RSRV: r_illegal <= 1'b1;
                            CMD_JUMP: r_pc <= w_pc_rel;
                            CMD_CMP: begin
`ifdef PPWM_CMP_IMM_EN
                                r_eq <= (w_cmp_a == w_cmp_b);
                                r_lt <= (w_cmp_a < w_cmp_b);
`else
                                if (w_func == 2'b11) begin
                                    r_illegal <= 1'b1;
                                end else begin
                                    r_eq <= (w_cmp_a == w_cmp_b);
                                    r_lt <= (w_cmp_a < w_cmp_b);
                                end
`endif
                            end
                            CMD_BRANCH: r_pc <= w_cond ? w_pc_rel : w_pc_inc;
                        endcase
                    end
                    S_WAIT: begin
                        if (r_gcnt == '1) begin
                            r_state <= S_RUN;
                            r_pc    <= w_pc_inc;
                        end
                    end
                    S_HALT: ;
                endcase
            end
        end
    end

    assign pwm_o     = r_pwm;
    assign pc_o      = r_pc;
    assign halted_o  = r_halted;
    assign illegal_o = r_illegal;
endmodule

// File: tb/tb_ppwm_seq.sv
// Directed bench for ppwm_seq with immediate-assertion checks at each comparison point.
module tb_ppwm_seq;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned IMM_W = 6;
    localparam int unsigned AW    = 4;
    localparam int unsigned IW    = IMM_W + 6;
    localparam int          PER   = 256;

    localparam logic [2:0] C_CTRL = 3'd0, C_SET = 3'd1, C_ARITH = 3'd2, C_SHIFT = 3'd3;
    localparam logic [2:0] C_RSRV = 3'd4, C_JUMP = 3'd5, C_CMP = 3'd6, C_BRANCH = 3'd7;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          en_i;
    logic          prog_we_i;
    logic [AW-1:0] prog_addr_i;
    logic [IW-1:0] prog_wdata_i;
    logic          pwm_o;
    logic [AW-1:0] pc_o;
    logic          halted_o;
    logic          illegal_o;

    int n_cmp = 0;
    int n_bad = 0;
    int c;

    ppwm_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IMM_W(IMM_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .prog_we_i(prog_we_i),
        .prog_addr_i(prog_addr_i), .prog_wdata_i(prog_wdata_i), .pwm_o(pwm_o),
        .pc_o(pc_o), .halted_o(halted_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [IW-1:0] ins(input logic [2:0] cmd, input logic tgt,
                                          input logic [1:0] fn, input int imm);
        logic [IMM_W-1:0] im;
        im = IMM_W'(imm);
        return {cmd, tgt, fn, im};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load(input int a, input logic [IW-1:0] w);
        prog_we_i    = 1'b1;
        prog_addr_i  = AW'(a);
        prog_wdata_i = w;
        @(negedge clk_i);
        prog_we_i    = 1'b0;
    endtask

    task automatic start(input string tag);
        en_i = 1'b1;
        @(negedge clk_i);
        chk({tag, "_pc0"}, 32'(pc_o), 32'd0);
    endtask

    task automatic stop();
        en_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic wait_halt(input string tag, input int exp_pc);
        for (int i = 0; i < 200 && !halted_o; i++) @(negedge clk_i);
        chk({tag, "_halted"}, 32'(halted_o), 32'd1);
        chk({tag, "_pc"}, 32'(pc_o), 32'(exp_pc));
    endtask

    task automatic wait_pc(input string tag, input int p);
        for (int i = 0; i < 600 && pc_o != AW'(p); i++) @(negedge clk_i);
        chk(tag, 32'(pc_o), 32'(p));
    endtask

    task automatic count_high(output int cnt);
        cnt = 0;
        for (int i = 0; i < PER; i++) begin
            cnt += int'(pwm_o);
            @(negedge clk_i);
        end
    endtask

    task automatic rot(input string tag, input logic [1:0] fn, input int amt, input int expv);
        stop();
        load(0, ins(C_SET, 1'b1, 2'b00, 1));
        load(1, ins(C_SHIFT, 1'b1, 2'b11, 1));
        load(2, ins(C_ARITH, 1'b1, 2'b00, 1));
        load(3, ins(C_SHIFT, 1'b1, fn, amt));
        load(4, ins(C_SET, 1'b0, 2'b00, expv));
        load(5, ins(C_CMP, 1'b0, 2'b10, 0));
        load(6, ins(C_BRANCH, 1'b0, 2'b00, 2));
        load(7, ins(C_CTRL, 1'b0, 2'b10, 0));
        load(8, ins(C_CTRL, 1'b0, 2'b10, 0));
        start(tag);
        wait_halt(tag, 8);
    endtask

    task automatic cb(input string tag, input int regv, input logic [1:0] bfn, input int exp_pc);
        stop();
        load(0, ins(C_SET, 1'b0, 2'b00, 10));
        load(1, ins(C_SET, 1'b1, 2'b00, regv));
        load(2, ins(C_CMP, 1'b0, 2'b10, 0));
        load(3, ins(C_BRANCH, 1'b0, bfn, 3));
        for (int a = 4; a < 7; a++) load(a, ins(C_CTRL, 1'b0, 2'b10, 0));
        start(tag);
        wait_halt(tag, exp_pc);
    endtask

    initial begin
        rst_ni = 1'b0; en_i = 1'b0; prog_we_i = 1'b0; prog_addr_i = '0; prog_wdata_i = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_pwm", 32'(pwm_o), 32'd0);
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        chk("rst_illegal", 32'(illegal_o), 32'd0);
        rst_ni = 1'b1;
        for (int a = 0; a < int'(DEPTH); a++) load(a, ins(C_CTRL, 1'b0, 2'b10, 0));

        // Ramp: duty grows by 4 each period and wraps to 0 after 64 steps.
        load(0, ins(C_SET, 1'b0, 2'b00, 0));
        load(1, ins(C_ARITH, 1'b0, 2'b00, 4));
        load(2, ins(C_CTRL, 1'b0, 2'b01, 0));
        load(3, ins(C_JUMP, 1'b0, 2'b00, -2));
        start("ramp");
        wait_pc("ramp_sync", 3);
        repeat (3) @(negedge clk_i);
        for (int j = 0; j < 63; j++) begin
            count_high(c);
            chk($sformatf("ramp_win%0d", j), 32'(c), 32'((4 * (j + 2)) % 256));
        end
        chk("ramp_in_wait", 32'(pc_o), 32'd2);

        // Reset while waiting, then re-run the untouched program.
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        en_i   = 1'b0;
        chk("wrst_pwm", 32'(pwm_o), 32'd0);
        chk("wrst_pc", 32'(pc_o), 32'd0);
        chk("wrst_halted", 32'(halted_o), 32'd0);
        chk("wrst_illegal", 32'(illegal_o), 32'd0);
        @(negedge clk_i);
        start("rerun");
        wait_pc("rerun_sync", 3);
        repeat (3) @(negedge clk_i);
        count_high(c);
        chk("rerun_win0", 32'(c), 32'd8);

        // Saturating add climbs to MAX; HALT keeps the PWM running.
        stop();
        load(0, ins(C_SET, 1'b0, 2'b00, 60));
        for (int a = 1; a < 9; a++) load(a, ins(C_ARITH, 1'b0, 2'b10, 31));
        load(9, ins(C_CTRL, 1'b0, 2'b10, 0));
        start("sat");
        wait_halt("sat", 9);
        count_high(c);
        chk("sat_duty", 32'(c), 32'd255);
        chk("halt_pc_hold", 32'(pc_o), 32'd9);
        chk("halt_still", 32'(halted_o), 32'd1);
        en_i = 1'b0;
        @(negedge clk_i);
        chk("endrop_pc", 32'(pc_o), 32'd0);
        chk("endrop_pwm", 32'(pwm_o), 32'd0);
        chk("endrop_halted", 32'(halted_o), 32'd0);

        // Subtract 16 from 3: clamps to 0, wraps to 243.
        stop();
        load(0, ins(C_SET, 1'b0, 2'b00, 3));
        load(1, ins(C_ARITH, 1'b0, 2'b11, 16));
        load(2, ins(C_CTRL, 1'b0, 2'b10, 0));
        start("subsat");
        wait_halt("subsat", 2);
        count_high(c);
        chk("subsat_duty", 32'(c), 32'd0);
        stop();
        load(1, ins(C_ARITH, 1'b0, 2'b01, 16));
        start("subwrap");
        wait_halt("subwrap", 2);
        count_high(c);
        chk("subwrap_duty", 32'(c), 32'd243);

        // reg = 0x81 then rotate/shift; result checked by CMP + BRANCH eq.
        rot("rotl1", 2'b10, 1, 3);
        rot("shl1", 2'b00, 1, 2);
        rot("rotr4", 2'b11, 4, 24);

        cb("lt_taken", 20, 2'b10, 6);
        cb("lt_not", 10, 2'b10, 4);
        prog_we_i = 1'b1; prog_addr_i = AW'(4); prog_wdata_i = ins(C_JUMP, 1'b0, 2'b00, 0);
        @(negedge clk_i);
        prog_we_i = 1'b0;
        cb("we_ignored", 10, 2'b10, 4);
        cb("eq_taken", 10, 2'b00, 6);
        cb("nlt_not", 20, 2'b11, 4);
        cb("neq_taken", 20, 2'b01, 6);

        // Reserved command: sticky illegal flag until reset.
        stop();
        chk("ill_pre", 32'(illegal_o), 32'd0);
        load(0, ins(C_RSRV, 1'b0, 2'b00, 0));
        load(1, ins(C_CTRL, 1'b0, 2'b10, 0));
        start("rsrv");
        wait_halt("rsrv", 1);
        chk("ill_set", 32'(illegal_o), 32'd1);
        stop();
        chk("ill_after_en", 32'(illegal_o), 32'd1);
        cb("ill_rerun", 20, 2'b10, 6);
        chk("ill_sticky", 32'(illegal_o), 32'd1);
        stop();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("ill_cleared", 32'(illegal_o), 32'd0);

`ifdef PPWM_CMP_IMM_EN
        load(0, ins(C_SET, 1'b0, 2'b00, 5));
        load(1, ins(C_CMP, 1'b0, 2'b11, 5));
        load(2, ins(C_BRANCH, 1'b0, 2'b00, 2));
        load(3, ins(C_CTRL, 1'b0, 2'b10, 0));
        load(4, ins(C_CTRL, 1'b0, 2'b10, 0));
        start("cmpimm");
        wait_halt("cmpimm", 4);
        chk("cmpimm_ill", 32'(illegal_o), 32'd0);
`else
        load(0, ins(C_CMP, 1'b0, 2'b11, 5));
        load(1, ins(C_CTRL, 1'b0, 2'b10, 0));
        start("cmp11");
        wait_halt("cmp11", 1);
        chk("cmp11_ill", 32'(illegal_o), 32'd1);
`endif
        stop();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
